// File: rtl/ycc_pkg.sv
// Shared YCbCr types and constants for the 4:2:2 to 4:4:4 upsampler
// and the downstream colour converter.
package ycc_pkg;

    localparam int PIX_W = 8;
    localparam int UPS_LATENCY = 3;
    localparam logic [PIX_W-1:0] CHROMA_MID = 8'd128;

    typedef struct packed {
        logic [PIX_W-1:0] y;
        logic [PIX_W-1:0] cb;
        logic [PIX_W-1:0] cr;
    } ycc_pix_t;

    typedef struct packed {
        logic             vs;
        logic             hs;
        logic             de;
        logic             ph;
        logic [PIX_W-1:0] y;
        logic [PIX_W-1:0] c;
    } ups_tap_t;

    // 9-bit sum keeps the carry, so the rounded mean never wraps
    function automatic logic [PIX_W-1:0] avg_round(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b
    );
        logic [PIX_W:0] s;
        s = {1'b0, a} + {1'b0, b} + (PIX_W+1)'(1);
        return s[PIX_W:1];
    endfunction

endpackage

// File: rtl/chroma_avg.sv
// Rounding average of two chroma samples, or pass-through of
// the first operand when interpolation is not wanted.
module chroma_avg
    import ycc_pkg::*;
(
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic             sel,
    output logic [PIX_W-1:0] y
);

    assign y = sel ? avg_round(a, b) : a;

endmodule

// File: rtl/ycbcr422to444.sv
// 4:2:2 to 4:4:4 chroma upsampler with a fixed 3-clock latency;
// odd pixels take the rounded mean of the neighbouring chroma pairs.
module ycbcr422to444
    import ycc_pkg::*;
#(
    parameter bit               INTERP       = 1'b1,
    parameter logic [PIX_W-1:0] CHROMA_BLANK = CHROMA_MID
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vs_in,
    input  logic             hs_in,
    input  logic             de_in,
    input  logic [PIX_W-1:0] y_in,
    input  logic [PIX_W-1:0] c_in,
    output logic             vs_out,
    output logic             hs_out,
    output logic             de_out,
    output logic [PIX_W-1:0] y_out,
    output logic [PIX_W-1:0] cb_out,
    output logic [PIX_W-1:0] cr_out
);

    localparam int CUR = UPS_LATENCY - 1;
    localparam int NX1 = UPS_LATENCY - 2;
    localparam int NX2 = UPS_LATENCY - 3;

    logic             phase_q;
    ups_tap_t         tap_in;
    ups_tap_t         tap_q [UPS_LATENCY];
    ups_tap_t         cur;
    logic [PIX_W-1:0] cb_hold_q;
    logic [PIX_W-1:0] cr_hold_q;
    logic             cr_ok_q;
    logic             nx1_ok;
    logic             nx2_ok;
    logic [PIX_W-1:0] cb_a;
    logic [PIX_W-1:0] cr_a;
    logic             cb_sel;
    logic             cr_sel;
    logic [PIX_W-1:0] cb_c;
    logic [PIX_W-1:0] cr_c;
    logic             vs_q;
    logic             hs_q;
    logic             de_q;
    ycc_pix_t         pix_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= de_in & ~phase_q;
        end
    end

    always_comb begin
        tap_in    = '0;
        tap_in.vs = vs_in;
        tap_in.hs = hs_in;
        tap_in.de = de_in;
        tap_in.ph = de_in & phase_q;
        tap_in.y  = y_in;
        tap_in.c  = c_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < UPS_LATENCY; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            tap_q[0] <= tap_in;
            for (int i = 1; i < UPS_LATENCY; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    assign cur = tap_q[CUR];

    // a gap in de between taps means the later samples belong to another line
    assign nx1_ok = cur.de & tap_q[NX1].de;
    assign nx2_ok = nx1_ok & tap_q[NX2].de;

    always_comb begin
        cb_a   = cur.c;
        cr_a   = CHROMA_BLANK;
        cb_sel = 1'b0;
        cr_sel = 1'b0;
        if (cur.ph) begin
            cb_a   = cb_hold_q;
            cr_a   = cur.c;
            cb_sel = INTERP & nx1_ok;
            cr_sel = INTERP & nx2_ok;
        end else if (nx1_ok) begin
            cr_a = tap_q[NX1].c;
        end else if (cr_ok_q) begin
            cr_a = cr_hold_q;
        end
    end

    chroma_avg u_cb_avg (
        .a   (cb_a),
        .b   (tap_q[NX1].c),
        .sel (cb_sel),
        .y   (cb_c)
    );

    chroma_avg u_cr_avg (
        .a   (cr_a),
        .b   (tap_q[NX2].c),
        .sel (cr_sel),
        .y   (cr_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cb_hold_q <= '0;
            cr_hold_q <= '0;
            cr_ok_q   <= 1'b0;
        end else if (!cur.de) begin
            cr_ok_q <= 1'b0;
        end else if (cur.ph) begin
            cr_hold_q <= cur.c;
            cr_ok_q   <= 1'b1;
        end else begin
            cb_hold_q <= cur.c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q  <= 1'b0;
            hs_q  <= 1'b0;
            de_q  <= 1'b0;
            pix_q <= '0;
        end else begin
            vs_q <= cur.vs;
            hs_q <= cur.hs;
            de_q <= cur.de;
            if (cur.de) begin
                pix_q <= '{y: cur.y, cb: cb_c, cr: cr_c};
            end else begin
                pix_q <= '0;
            end
        end
    end

    assign vs_out = vs_q;
    assign hs_out = hs_q;
    assign de_out = de_q;
    assign y_out  = pix_q.y;
    assign cb_out = pix_q.cb;
    assign cr_out = pix_q.cr;

endmodule

// File: tb/tb_ycbcr422to444.sv
// Scoreboard bench for ycbcr422to444: two instances (interpolating and
// replicating) share one stimulus stream and one line-level reference.
module tb_ycbcr422to444;
    import ycc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs_in = 1'b0;
    logic       hs_in = 1'b0;
    logic       de_in = 1'b0;
    logic [7:0] y_in = '0;
    logic [7:0] c_in = '0;

    logic       vs1, hs1, de1, vs0, hs0, de0;
    logic [7:0] y1, cb1, cr1, y0, cb0, cr0;

    typedef struct {
        logic [7:0] y;
        logic [7:0] cb1;
        logic [7:0] cr1;
        logic [7:0] cb0;
        logic [7:0] cr0;
    } exp_t;

    exp_t       sbq[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] ly[64];
    logic [7:0] lc[64];
    logic [3:0] mvs, mhs, mde;

    always #5 clk = ~clk;

    ycbcr422to444 #(.INTERP(1'b1), .CHROMA_BLANK(8'd128)) dut_i1 (
        .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .y_in(y_in), .c_in(c_in), .vs_out(vs1), .hs_out(hs1), .de_out(de1),
        .y_out(y1), .cb_out(cb1), .cr_out(cr1)
    );

    ycbcr422to444 #(.INTERP(1'b0), .CHROMA_BLANK(8'd128)) dut_i0 (
        .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .y_in(y_in), .c_in(c_in), .vs_out(vs0), .hs_out(hs0), .de_out(de0),
        .y_out(y0), .cb_out(cb0), .cr_out(cr0)
    );

    function automatic int ravg(input int a, input int b);
        return (a + b + 1) / 2;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: build each output pixel of a whole line from its pairs
    task automatic push_line(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int   k;
            int   cr;
            k    = i / 2;
            e.y  = ly[i];
            if (i % 2 == 0) begin
                e.cb1 = lc[i];
                e.cb0 = lc[i];
                if (i + 1 < n) cr = int'(lc[i+1]);
                else if (k > 0) cr = int'(lc[i-1]);
                else cr = 128;
                e.cr1 = 8'(cr);
                e.cr0 = 8'(cr);
            end else begin
                e.cb0 = lc[i-1];
                e.cr0 = lc[i];
                e.cb1 = (i + 1 < n) ? 8'(ravg(int'(lc[i-1]), int'(lc[i+1]))) : lc[i-1];
                e.cr1 = (i + 2 < n) ? 8'(ravg(int'(lc[i]), int'(lc[i+2]))) : lc[i];
            end
            sbq.push_back(e);
        end
    endtask

    task automatic drive_pix(input logic de, input logic [7:0] y, input logic [7:0] c);
        @(posedge clk);
        #1;
        de_in = de;
        y_in  = y;
        c_in  = c;
        vs_in = 1'($urandom);
        hs_in = 1'($urandom);
    endtask

    task automatic drive_line(input int n, input int gap);
        push_line(n);
        for (int i = 0; i < n; i++) drive_pix(1'b1, ly[i], lc[i]);
        for (int g = 0; g < gap; g++) drive_pix(1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic rand_line(input int n);
        for (int i = 0; i < n; i++) begin
            ly[i] = 8'($urandom);
            lc[i] = 8'($urandom);
        end
    endtask

    // sync/de reference: value sampled three edges earlier, zero across reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mvs <= '0;
            mhs <= '0;
            mde <= '0;
        end else begin
            mvs <= {mvs[2:0], vs_in};
            mhs <= {mhs[2:0], hs_in};
            mde <= {mde[2:0], de_in};
        end
    end

    always @(negedge clk) begin
        chk("vs_out", int'(vs1), int'(mvs[3]));
        chk("hs_out", int'(hs1), int'(mhs[3]));
        chk("de_out", int'(de1), int'(mde[3]));
        chk("vs_out_i0", int'(vs0), int'(mvs[3]));
        chk("hs_out_i0", int'(hs0), int'(mhs[3]));
        chk("de_out_i0", int'(de0), int'(mde[3]));
        if (de1) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("y_i1", int'(y1), int'(e.y));
                chk("cb_i1", int'(cb1), int'(e.cb1));
                chk("cr_i1", int'(cr1), int'(e.cr1));
                chk("y_i0", int'(y0), int'(e.y));
                chk("cb_i0", int'(cb0), int'(e.cb0));
                chk("cr_i0", int'(cr0), int'(e.cr0));
            end
        end else begin
            chk("idle_y", int'(y1), 0);
            chk("idle_cb", int'(cb1), 0);
            chk("idle_cr", int'(cr1), 0);
            chk("idle_y_i0", int'(y0), 0);
            chk("idle_cb_i0", int'(cb0), 0);
            chk("idle_cr_i0", int'(cr0), 0);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_pix(1'b0, 8'd0, 8'd0);

        ly[0] = 8'd10; ly[1] = 8'd20; ly[2] = 8'd30; ly[3] = 8'd40;
        lc[0] = 8'd100; lc[1] = 8'd200; lc[2] = 8'd110; lc[3] = 8'd210;
        drive_line(4, 2);

        lc[0] = 8'd101; lc[1] = 8'd7; lc[2] = 8'd102; lc[3] = 8'd9;
        drive_line(4, 2);
        lc[0] = 8'd0; lc[1] = 8'd7; lc[2] = 8'd255; lc[3] = 8'd9;
        drive_line(4, 2);

        lc[0] = 8'd50; lc[1] = 8'd60; lc[2] = 8'd70;
        drive_line(3, 2);
        lc[0] = 8'd90;
        drive_line(1, 2);

        lc[0] = 8'd10; lc[1] = 8'd20; lc[2] = 8'd30; lc[3] = 8'd40;
        drive_line(4, 1);
        lc[0] = 8'd200; lc[1] = 8'd220; lc[2] = 8'd240; lc[3] = 8'd250;
        drive_line(4, 1);
        rand_line(5);
        drive_line(5, 1);
        rand_line(2);
        drive_line(2, 1);

        for (int l = 0; l < 40; l++) begin
            int n;
            n = $urandom_range(1, 12);
            rand_line(n);
            drive_line(n, $urandom_range(1, 3));
        end

        // reset lands before any pixel of this line reaches the outputs
        for (int i = 0; i < 3; i++) drive_pix(1'b1, 8'($urandom), 8'($urandom));
        @(posedge clk);
        #2;
        rst = 1'b1;
        drive_pix(1'b1, 8'($urandom), 8'($urandom));
        drive_pix(1'b1, 8'($urandom), 8'($urandom));
        rand_line(7);
        push_line(7);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        de_in = 1'b1;
        y_in  = ly[0];
        c_in  = lc[0];
        vs_in = 1'($urandom);
        hs_in = 1'($urandom);
        for (int i = 1; i < 7; i++) drive_pix(1'b1, ly[i], lc[i]);
        drive_pix(1'b0, 8'($urandom), 8'($urandom));

        for (int l = 0; l < 10; l++) begin
            int n;
            n = $urandom_range(1, 10);
            rand_line(n);
            drive_line(n, $urandom_range(1, 2));
        end

        repeat (6) drive_pix(1'b0, 8'($urandom), 8'($urandom));
        chk("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ycbcr422to444.md
# ycbcr422to444

Chroma upsampler that converts an interleaved 4:2:2 YCbCr pixel stream (8-bit Y plus an 8-bit Cb/Cr multiplexed chroma channel) into full 4:4:4 YCbCr. It sits directly upstream of the YCbCr-to-RGB converter and drives its y/cb/cr and vs/hs/de inputs. Odd-pixel chroma is interpolated from neighbouring co-sited samples. All outputs run at a fixed 3-clock latency.

## Interface
- INTERP, default 1: 1 = odd pixels use the rounded average of adjacent pairs; 0 = odd pixels replicate their own pair's chroma.
- CHROMA_BLANK, default 8'd128: Cr substitute for a line that ends before any Cr sample arrives.
- clk  in  1  pixel clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- vs_in  in  1  vertical sync.
- hs_in  in  1  horizontal sync.
- de_in  in  1  data enable; each rising edge starts a new line.
- y_in  in  8  luma.
- c_in  in  8  chroma: Cb on even phase, Cr on odd phase.
- vs_out  out  1  vs_in delayed 3 clocks.
- hs_out  out  1  hs_in delayed 3 clocks.
- de_out  out  1  de_in delayed 3 clocks.
- y_out  out  8  luma, 4:4:4.
- cb_out  out  8  Cb, 4:4:4.
- cr_out  out  8  Cr, 4:4:4.

## Operation
- Phase toggle: cleared on every cycle with de_in=0. Toggles on every cycle with de_in=1. Phase is 0 on the first active pixel of each line.
- Pairs: pixel 2k (phase 0) carries Y(2k) and Cb(k). Pixel 2k+1 (phase 1) carries Y(2k+1) and Cr(k).
- Even output pixel 2k: Cb = Cb(k), Cr = Cr(k).
- Odd output pixel 2k+1, INTERP=1:
  - Cb = (Cb(k)+Cb(k+1)+1)>>1 and Cr = (Cr(k)+Cr(k+1)+1)>>1.
  - Sums are 9-bit, so there is no overflow.
- Odd output pixel 2k+1, INTERP=0: Cb = Cb(k), Cr = Cr(k).
- Line end, odd length (de falls after a phase-0 pixel 2k):
  - That pixel uses Cb(k) and Cr(k-1).
  - If k=0 (one-pixel line), Cr = CHROMA_BLANK.
- Line end, even length (de falls after phase-1 pixel 2k+1): no pair k+1 exists, so that pixel uses Cb(k) and Cr(k) (replicate).
- Pair k+1 incomplete (de falls after Cb(k+1), before Cr(k+1)): pixel 2k+1 uses Cr(k) for Cr, and the average for Cb.
- A de_in low gap mid-line ends the line. Samples from before the gap are never averaged with samples after it.
- Outputs when de_out=0: y_out, cb_out and cr_out are 8'd0. This matches the downstream converter, which zeroes its datapath outside de.
- vs and hs pass through delay-only. They are not gated by de.

## Timing
- Latency is exactly 3 clocks for every output: an input sampled at edge t appears on the outputs after edge t+3.
- Why 3 clocks: odd pixel 2k+1 needs Cr(k+1), which arrives 2 clocks later, plus one output register.
- All outputs are registered; there is no combinational input-to-output path.
- Reset value of every output is 0 (vs_out, hs_out, de_out, y_out, cb_out, cr_out). Delay lines, chroma holds and phase are also cleared.
- Reset asserted mid-line:
  - Outputs go to 0 immediately (asynchronously).
  - After release, the first de_in=1 cycle is treated as phase 0, even if the line was in progress.
- Back-to-back lines: de_in low for a single clock is sufficient to separate lines and reset phase.
- Throughput is one pixel per clock. There is no backpressure and no stall.

## Structure
- Package ycc_pkg:
  - PIX_W=8.
  - UPS_LATENCY=3.
  - CHROMA_MID=8'd128.
  - Packed struct ycc_pix_t {y, cb, cr}, shared with the downstream converter's future wrapper.
- Sub-module chroma_avg:
  - Combinational rounding average of two 8-bit values.
  - Select input picks average or pass-through of the first operand.
  - Instantiated twice (Cb, Cr).
- Top level contains:
  - 3-deep delay line of {vs, hs, de, y, c, phase}.
  - Held Cb/Cr registers for pairs k and k-1.
  - End-of-line detection from the delayed de taps.
  - Output registers.

## Test plan
- Line with Y=10,20,30,40 and c=Cb100,Cr200,Cb110,Cr210 (INTERP=1):
  - Outputs 3 clocks later: (10,100,200), (20,105,205), (30,110,210), (40,110,210).
  - de_out is high for exactly 4 clocks.
- Same line with INTERP=0: (10,100,200), (20,100,200), (30,110,210), (40,110,210).
- Rounding check: Cb(0)=101, Cb(1)=102 → odd pixel Cb=102. Cb 0 and 255 → 128.
- Odd-length lines:
  - Three pixels, c=Cb50,Cr60,Cb70 → third pixel (Cb,Cr)=(70,60).
  - One-pixel line with Cb=90 → (90,128).
- Two lines separated by a 1-clock de gap, with the last chroma of line 1 ≠ the first of line 2 → no cross-line averaging; the second line's first pixel is phase 0.
- Reset pulse asserted mid-line:
  - All outputs read 0 during reset.
  - After release, a new line's output is correct from its first pixel.
  - vs_out/hs_out track the inputs with a 3-clock delay from the first post-reset edge.
